poly_bram_reader: RTL and testbench
===================================

# poly_bram_reader

Streams one polynomial (N_COEFF coefficients) out of a 256x12 dual-port coefficient BRAM, in address order, onto a valid/ready stream. It drives one BRAM port as a read-only master and absorbs the BRAM's 1-cycle registered read latency. A 2-entry output buffer gives full throughput under continuous `m_ready` and correct behaviour under arbitrary backpressure. It sits between polynomial storage and downstream consumers: NTT/butterfly input, packing/serialisation, hash absorb.

## Interface
- `N_COEFF`, 256: coefficients streamed per run (1..2^ADDR_W).
- `ADDR_W`, 8: BRAM address width.
- `DATA_W`, 12: coefficient width.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to stream a polynomial; sampled only when `busy`=0.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse after the final beat's handshake.
- `bram_en` out 1: BRAM port enable; high only in cycles that issue a read.
- `bram_we` out 1: constant 0.
- `bram_addr` out ADDR_W: read address.
- `bram_din` out DATA_W: constant 0.
- `bram_dout` in DATA_W: BRAM read data, valid the cycle after `bram_en`.
- `m_data` out DATA_W: coefficient.
- `m_index` out ADDR_W: address/index of `m_data`.
- `m_last` out 1: high with the beat whose index is N_COEFF-1.
- `m_valid` out 1: beat valid.
- `m_ready` in 1: consumer accepts; a handshake occurs when `m_valid && m_ready`.

## Operation
- FSM states are IDLE, RUN and FINISH.
  - IDLE to RUN on `start`. Clear issue counter, accept counter and buffer.
  - RUN to FINISH in the cycle after the handshake of beat N_COEFF-1.
  - FINISH to IDLE after one cycle. `done` is high in FINISH only.
- `busy` is high in RUN and FINISH.
- `start` during `busy` is ignored; no queuing.
- Issue counter is ADDR_W+1 bits, so N_COEFF=2^ADDR_W does not wrap early. `bram_addr` is its low ADDR_W bits.
- Read issue rule: in RUN, issue when issued < N_COEFF and (buf_count + inflight < 2, or a handshake occurs this cycle).
  - `inflight` is 1 if `bram_en` was high in the previous cycle.
  - Buffer overflow is impossible by construction.
- Each in-flight read is written into the 2-entry FIFO at the end of the cycle its data is valid. The FIFO carries data, index and last.
- `m_valid` = FIFO non-empty; head drives `m_data`, `m_index` and `m_last`.
- Once `m_valid` rises, `m_data`, `m_index` and `m_last` stay stable until the handshake.
- Beats leave strictly in index order 0..N_COEFF-1: no duplicates, no gaps.
- Simultaneous push and pop in one cycle is legal, and count is unchanged.
- Reset values: `busy`=0, `done`=0, `bram_en`=0, `bram_addr`=0, `m_valid`=0, `m_data`=0, `m_index`=0, `m_last`=0, FIFO empty, FSM in IDLE.
- Reset mid-run aborts immediately. In-flight BRAM data is discarded, and no `done` is emitted.

## Timing
- `start` sampled at the end of cycle c0.
- c1: `busy`=1, `bram_en`=1, `bram_addr`=0.
- c2: `bram_dout` valid; it is captured at the end of c2.
- c3: first `m_valid`. Start-to-first-beat latency is 3 cycles.
- With `m_ready` held high: one beat per cycle, beat k in c3+k, last beat in c(2+N_COEFF), `done` in c(3+N_COEFF), `busy` low from c(4+N_COEFF).
- A new `start` is accepted in c(4+N_COEFF) at the earliest.
- During a stall, at most 2 reads beyond the last accepted beat are outstanding (buffered plus in flight).
- After `m_ready` rises following a stall, a beat is presented every cycle with no bubble.

## Test plan
- Continuous stream: mem[i] = (17*i) mod 3329, `start` in c0, `m_ready`=1.
  - 256 beats with `m_data` = mem[k] and `m_index` = k in c3+k.
  - `m_last` only at k=255 (c258); `done` pulse in c259.
- Backpressure: `m_ready` random at 50%, plus a 10-cycle hold-low at beat 100.
  - Exact in-order sequence 0..255; data stable while stalled.
  - `bram_en` count = 256; at most 2 outstanding reads during the stall.
- Start while busy: pulse `start` in c50 and c259.
  - Both ignored: exactly 256 beats, one `done`.
  - Next `start` in c260 restarts from index 0.
- Reset mid-run: `rst` in the cycle of the beat-100 handshake.
  - Next cycle: `m_valid`=0, `bram_en`=0, `busy`=0, no `done`.
  - A later `start` streams 0..255 correctly.
- `N_COEFF`=16: 16 beats with `m_last` at index 15 and `done` at c19. Addresses above 15 are never issued.

Source files
------------

// File: rtl/poly_bram_reader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | poly_bram_reader_if : valid/ready coefficient stream (data,index,last) |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface poly_bram_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] index;
  logic              last;
  logic              valid;
  logic              ready;

  modport master (output data, output index, output last, output valid, input ready);
  modport slave  (input data, input index, input last, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/poly_bram_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | poly_bram_reader : streams N_COEFF BRAM words in address order         |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module poly_bram_reader #(
  parameter int N_COEFF = 256,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_din_o,
  input  logic [DATA_W-1:0] bram_dout_i,
  poly_bram_reader_if.master m
);

  localparam logic [1:0]      c_IDLE   = 2'd0;
  localparam logic [1:0]      c_RUN    = 2'd1;
  localparam logic [1:0]      c_FINISH = 2'd2;
  localparam logic [ADDR_W:0] c_N      = (ADDR_W+1)'(N_COEFF);
  localparam logic [ADDR_W:0] c_LAST   = (ADDR_W+1)'(N_COEFF - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] infl_idx_q;
  logic              infl_last_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [ADDR_W-1:0] fifo_idx_q  [2];
  logic [1:0]        fifo_last_q;
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;

  logic w_start, w_valid, w_pop, w_push, w_issue;

  always_comb begin
    w_start = (state_q == c_IDLE) && start_i;
    w_valid = (count_q != 2'd0);
    w_pop   = w_valid && m.ready;
    w_push  = inflight_q;
    // Buffered plus in-flight never exceeds two, so a pop is what frees a slot.
    w_issue = (state_q == c_RUN) && (issued_q < c_N) &&
              ((({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) || w_pop);

    state_d  = state_q;
    issued_d = issued_q;
    case (state_q)
      c_IDLE:   if (start_i) begin
                  state_d  = c_RUN;
                  issued_d = '0;
                end
      c_RUN:    begin
                  if (w_issue) issued_d = issued_q + 1'b1;
                  if (w_pop && fifo_last_q[rd_ptr_q]) state_d = c_FINISH;
                end
      c_FINISH: state_d = c_IDLE;
      default:  state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_IDLE;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      fifo_last_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      inflight_q  <= w_issue;
      infl_idx_q  <= issued_q[ADDR_W-1:0];
      infl_last_q <= (issued_q == c_LAST);
      if (w_start) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (w_push) begin
          fifo_data_q[wr_ptr_q] <= bram_dout_i;
          fifo_idx_q[wr_ptr_q]  <= infl_idx_q;
          fifo_last_q[wr_ptr_q] <= infl_last_q;
          wr_ptr_q              <= ~wr_ptr_q;
        end
        if (w_pop) rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  assign busy_o      = (state_q != c_IDLE);
  assign done_o      = (state_q == c_FINISH);
  assign bram_en_o   = w_issue;
  assign bram_we_o   = 1'b0;
  assign bram_addr_o = issued_q[ADDR_W-1:0];
  assign bram_din_o  = '0;
  assign m.valid     = w_valid;
  assign m.data      = fifo_data_q[rd_ptr_q];
  assign m.index     = fifo_idx_q[rd_ptr_q];
  assign m.last      = w_valid && fifo_last_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_poly_bram_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_poly_bram_reader : directed bench, 256- and 16-coefficient readers  |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_poly_bram_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] mem [256];

  // Reader A: 256 coefficients
  logic        start_a = 1'b0;
  logic        busy_a, done_a, en_a, we_a;
  logic [7:0]  addr_a;
  logic [11:0] din_a, dout_a;
  poly_bram_reader_if #(.ADDR_W(8), .DATA_W(12)) if_a ();

  poly_bram_reader #(.N_COEFF(256), .ADDR_W(8), .DATA_W(12)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .bram_en_o(en_a), .bram_we_o(we_a), .bram_addr_o(addr_a), .bram_din_o(din_a),
    .bram_dout_i(dout_a), .m(if_a.master)
  );

  // Reader B: 16 coefficients
  logic        start_b = 1'b0;
  logic        busy_b, done_b, en_b, we_b;
  logic [7:0]  addr_b;
  logic [11:0] din_b, dout_b;
  poly_bram_reader_if #(.ADDR_W(8), .DATA_W(12)) if_b ();

  poly_bram_reader #(.N_COEFF(16), .ADDR_W(8), .DATA_W(12)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .bram_en_o(en_b), .bram_we_o(we_b), .bram_addr_o(addr_b), .bram_din_o(din_b),
    .bram_dout_i(dout_b), .m(if_b.master)
  );

  // Registered-read BRAM models
  always @(posedge clk) begin
    if (en_a) dout_a <= mem[addr_a];
    if (en_b) dout_b <= mem[addr_b];
  end

  int en_cnt_a = 0, hs_cnt_a = 0, done_cnt_a = 0, max_out_a = 0;
  int en_cnt_b = 0, max_addr_b = 0;
  always @(posedge clk) begin
    if (en_a) en_cnt_a = en_cnt_a + 1;
    if (if_a.valid && if_a.ready) hs_cnt_a = hs_cnt_a + 1;
    if (done_a) done_cnt_a = done_cnt_a + 1;
    if (en_cnt_a - hs_cnt_a > max_out_a) max_out_a = en_cnt_a - hs_cnt_a;
    if (en_b) begin
      en_cnt_b = en_cnt_b + 1;
      if (int'(addr_b) > max_addr_b) max_addr_b = int'(addr_b);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge of c0; returns at the falling edge of c260.
  task automatic run_cont(input bit busy_starts);
    int hs0, dn0;
    hs0 = hs_cnt_a;
    dn0 = done_cnt_a;
    start_a = 1'b1;
    if_a.ready = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("c1_busy_en_addr", {busy_a, en_a, addr_a, if_a.valid}, {1'b1, 1'b1, 8'd0, 1'b0});
    @(negedge clk);
    check("c2_valid", {31'd0, if_a.valid}, 32'd0);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      check("cont_beat", {if_a.valid, if_a.data, if_a.index, if_a.last, done_a},
            {1'b1, mem[k], 8'(k), (k == 255), 1'b0});
      if (busy_starts) start_a = (k == 47);
    end
    @(negedge clk);
    check("c259_done", {done_a, if_a.valid, busy_a}, {1'b1, 1'b0, 1'b1});
    start_a = busy_starts;
    @(negedge clk);
    start_a = 1'b0;
    check("c260_idle", {busy_a, done_a}, {1'b0, 1'b0});
    check("cont_beats", hs_cnt_a - hs0, 256);
    check("cont_dones", done_cnt_a - dn0, 1);
  endtask

  initial begin
    int k;
    int hold;
    int en0, hs0, dn0;
    bit hold_used;
    bit stalled;
    logic [31:0] held;

    for (int i = 0; i < 256; i++) mem[i] = 12'((17 * i) % 3329);
    if_a.ready = 1'b0;
    if_b.ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_a", {busy_a, done_a, en_a, addr_a, if_a.valid, if_a.data, if_a.index, if_a.last}, 32'd0);
    check("reset_b", {busy_b, done_b, en_b, addr_b, if_b.valid, if_b.data, if_b.index, if_b.last}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Continuous stream, with starts at c50 and c259 that must be ignored
    run_cont(1'b1);

    // Backpressure run, started in c260 of the previous run
    en0 = en_cnt_a;
    hs0 = hs_cnt_a;
    dn0 = done_cnt_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0; hold = 0; hold_used = 1'b0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 3000 && k < 256; cyc++) begin
      @(negedge clk);
      if (stalled) check("stall_stable", {if_a.data, if_a.index, if_a.last}, held);
      if (hold > 0) begin
        if_a.ready = 1'b0;
        hold--;
      end else if (if_a.valid && if_a.index == 8'd100 && !hold_used) begin
        if_a.ready = 1'b0;
        hold = 9;
        hold_used = 1'b1;
      end else begin
        if_a.ready = 1'($urandom_range(0, 1));
      end
      if (if_a.valid && if_a.ready) begin
        check("bp_beat", {if_a.data, if_a.index, if_a.last}, {mem[k], 8'(k), (k == 255)});
        k++;
      end
      stalled = if_a.valid && !if_a.ready;
      held = {11'd0, if_a.data, if_a.index, if_a.last};
    end
    check("bp_all_beats_seen", k, 256);
    @(negedge clk);
    check("bp_done", {done_a, if_a.valid}, {1'b1, 1'b0});
    @(negedge clk);
    check("bp_idle", busy_a, 1'b0);
    check("bp_beats", hs_cnt_a - hs0, 256);
    check("bp_reads", en_cnt_a - en0, 256);
    check("bp_dones", done_cnt_a - dn0, 1);
    check("max_outstanding_le2", (max_out_a <= 2), 1);

    // Reset in the cycle of the beat-100 handshake
    start_a = 1'b1;
    if_a.ready = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 400 && k == 0; cyc++) begin
      @(negedge clk);
      if (if_a.valid && if_a.index == 8'd100) begin
        rst = 1'b1;
        k = 1;
      end
    end
    check("rst_reached_beat100", k, 1);
    dn0 = done_cnt_a;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort", {if_a.valid, en_a, busy_a, done_a}, 32'd0);
    repeat (5) @(negedge clk);
    check("rst_no_done", done_cnt_a - dn0, 0);
    check("rst_quiet", {if_a.valid, en_a, busy_a}, 32'd0);

    // Fresh run after the abort
    run_cont(1'b0);

    // 16-coefficient reader
    en0 = en_cnt_b;
    start_b = 1'b1;
    if_b.ready = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_c1", {busy_b, en_b, addr_b}, {1'b1, 1'b1, 8'd0});
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      check("b_beat", {if_b.valid, if_b.data, if_b.index, if_b.last, done_b},
            {1'b1, mem[j], 8'(j), (j == 15), 1'b0});
    end
    @(negedge clk);
    check("b_c19_done", {done_b, if_b.valid}, {1'b1, 1'b0});
    @(negedge clk);
    check("b_idle", {busy_b, done_b}, {1'b0, 1'b0});
    check("b_reads", en_cnt_b - en0, 16);
    check("b_max_addr", max_addr_b, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
